// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small circular transmit FIFO in front of the serialiser.
// TX falls two edges after a byte is pushed into an empty FIFO; tx_ready drops only while the FIFO is full.
module uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [12:0]                   baud,
  output logic                          TX,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      shift_q, shift_d;
  logic [12:0]     baud_lat_q, baud_lat_d;
  logic [12:0]     cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            push, pop, bit_end, fifo_empty;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (cnt_q == 13'd0);

  assign TX         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next state; a pop always starts a new frame and relatches the divisor.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_lat_d = baud_lat_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    pop        = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? baud_lat_q : cnt_q - 13'd1;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d    = START;
      shift_d    = mem_q[rd_ptr_q];
      baud_lat_d = baud;
      cnt_d      = baud;
    end
  end

  // Outputs are registered from the current state, so the line lags the FSM by one cycle.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    done_d = (state_q == STOP) && bit_end;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= 8'd0;
      baud_lat_q <= 13'd0;
      cnt_q      <= 13'd0;
      bit_idx_q  <= 3'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      baud_lat_q <= baud_lat_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued, a line monitor decodes each frame and compares.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [12:0] baud;
  logic        TX;
  logic        busy;
  logic        tx_done;
  logic [2:0]  fifo_count;

  uart_tx #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .baud       (baud),
    .TX         (TX),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];
  int per_q[$];
  logic [12:0] b1 = 13'd0;
  logic [12:0] b2 = 13'd0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Divisor history: the value latched for a frame is the one seen two negedges before TX falls.
  always @(negedge clk) begin
    b2 <= b1;
    b1 <= baud;
  end

  // Reference model of the FIFO contents as seen from outside: every accepted byte, in order.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (tx_valid && tx_ready) exp_q.push_back(tx_data);
  end

  // Line monitor: decodes 8N1 frames and checks every cycle of each bit.
  initial begin
    int p;
    logic [9:0] fb;
    logic [7:0] e;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (TX === 1'b0) begin
        p = int'(b2) + 1;
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 1, 0);
          e = 8'h00;
        end else begin
          e = exp_q.pop_front();
        end
        fb = {1'b1, e, 1'b0};
        ab = 1'b0;
        for (int b = 0; b < 10 && !ab; b++) begin
          for (int c = 0; c < p && !ab; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (rst) begin
              ab = 1'b1;
            end else begin
              chk("tx_bit", int'(TX), int'(fb[b]));
              chk("busy_in_frame", int'(busy), 1);
              chk("tx_done_pos", int'(tx_done), int'(b == 9 && c == p - 1));
            end
          end
        end
        if (!ab) begin
          frames_seen++;
          per_q.push_back(p);
        end
      end else begin
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(tx_done), 0);
      end
    end
  end

  task automatic push_hold(input logic [7:0] b);
    int w;
    tx_data  = b;
    tx_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!tx_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && busy == 1'b0 && fifo_count == 3'd0) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", int'(w >= 20000), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic watch_run(input string tag, input int want_busy, input int want_done, input int want_gap);
    int w, nb, nd, last;
    w = 0; nb = 0; nd = 0; last = -1;
    @(negedge clk);
    while (busy !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_busy_start"}, int'(busy === 1'b1), 1);
    while (busy === 1'b1 && nb < 5000) begin
      if (tx_done === 1'b1) begin
        if (last >= 0) chk({tag, "_done_gap"}, nb - last, want_gap);
        last = nb;
        nd++;
      end
      nb++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, nb, want_busy);
    chk({tag, "_done_cnt"}, nd, want_done);
  endtask

  initial begin
    int k, f0;
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    int k, f0;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; baud = 13'd4;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tx", int'(TX), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_count", int'(fifo_count), 0);
    repeat (2) @(posedge clk);
    #1;

    // Basic frame, push-to-TX latency, busy/tx_done envelope
    fork
      begin
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (TX !== 1'b0 && k < 20);
        chk("latency_negedges", k, 3);
      end
      watch_run("basic", 50, 1, 0);
    join
    drain();

    // Back-to-back frames, no idle gap
    baud = 13'd2;
    repeat (2) @(posedge clk);
    #1;
    f0 = frames_seen;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          tx_data = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h55 : 8'h81;
          tx_valid = 1'b1;
          @(negedge clk);
          chk("b2b_ready", int'(tx_ready), 1);
          @(posedge clk); #1;
        end
        tx_valid = 1'b0;
      end
      watch_run("b2b", 120, 4, 30);
    join
    drain();
    chk("b2b_frames", frames_seen - f0, 4);

    // Full FIFO with tx_valid held
    baud = 13'd10;
    repeat (2) @(posedge clk);
    #1;
    f0 = frames_seen;
    for (int i = 0; i < 6; i++) begin
      push_hold(8'h10 + 8'(i));
      if (i == 1) chk("fifo_push_pop_same_edge", int'(fifo_count), 1);
      if (i == 4) begin
        chk("fifo_full_count", int'(fifo_count), 4);
        chk("fifo_full_ready", int'(tx_ready), 0);
      end
    end
    drain();
    chk("full_frames", frames_seen - f0, 6);

    // Divisor changed during data bit 2 of the first frame
    baud = 13'd3;
    repeat (2) @(posedge clk);
    #1;
    per_q.delete();
    push_hold(8'h3C);
    push_hold(8'h99);
    repeat (14) @(posedge clk);
    #1;
    baud = 13'd7;
    drain();
    chk("baudchg_frames", per_q.size(), 2);
    if (per_q.size() == 2) begin
      chk("baudchg_period1", per_q[0], 4);
      chk("baudchg_period2", per_q[1], 8);
    end

    // baud = 0: one cycle per bit
    baud = 13'd0;
    repeat (2) @(posedge clk);
    #1;
    f0 = frames_seen;
    fork
      begin
        push_hold(8'hC3);
        push_hold(8'h5A);
        push_hold(8'h01);
      end
      watch_run("baud0", 30, 3, 10);
    join
    drain();
    chk("baud0_frames", frames_seen - f0, 3);

    // Reset mid-frame with two bytes queued
    baud = 13'd5;
    repeat (2) @(posedge clk);
    #1;
    push_hold(8'hE7);
    push_hold(8'h42);
    push_hold(8'h18);
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_tx", int'(TX), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(tx_done), 0);
    chk("midrst_ready", int'(tx_ready), 1);
    chk("midrst_count", int'(fifo_count), 0);
    k = 0;
    repeat (300) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0) k++;
    end
    chk("post_rst_activity", k, 0);

    // Randomized traffic with random divisor changes
    f0 = frames_seen;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) baud = 13'($urandom_range(0, 6));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      push_hold(8'($urandom));
    end
    drain();
    chk("rand_frames", frames_seen - f0, 60);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
